// File: rtl/icache_refill.sv
// Instruction-cache refill engine: turns a line-aligned miss address into one AXI4 INCR
// read burst and assembles the returned beats into a full cache line for the ICache write path.
module icache_refill #(
   parameter int ADDR_WIDTH = 32,
   parameter int WORD_WIDTH = 32,
   parameter int BEATS      = 8,
   parameter int AXI_ID     = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [ADDR_WIDTH-1:0]       req_addr,
   input  logic                        flush,
   output logic                        line_valid,
   output logic [BEATS*WORD_WIDTH-1:0] line_data,
   output logic                        line_err,
   output logic                        arvalid,
   input  logic                        arready,
   output logic [ADDR_WIDTH-1:0]       araddr,
   output logic [7:0]                  arlen,
   output logic [2:0]                  arsize,
   output logic [1:0]                  arburst,
   output logic [3:0]                  arid,
   input  logic                        rvalid,
   output logic                        rready,
   input  logic [WORD_WIDTH-1:0]       rdata,
   input  logic [1:0]                  rresp,
   input  logic                        rlast
);

   localparam int CNT_W = $clog2(BEATS);
   localparam int OFF_W = $clog2(BEATS * WORD_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] beat_cnt;
   logic             err;
   logic             drop;
   logic             line_pend;
   logic             last_slot;
   logic             beat_err;

   assign arlen   = 8'(BEATS - 1);
   assign arsize  = 3'($clog2(WORD_WIDTH / 8));
   assign arburst = 2'b01;
   assign arid    = 4'(AXI_ID);

   // A beat is faulty on a non-OKAY response or when rlast disagrees with the slot position.
   assign last_slot = (beat_cnt == CNT_W'(BEATS - 1));
   assign beat_err  = (rresp != 2'b00) || (rlast != last_slot);

   // A flush arriving in the DONE cycle itself must still hide the line, hence the gate on flush.
   assign line_valid = line_pend && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         araddr    <= '0;
         line_pend <= 1'b0;
         line_err  <= 1'b0;
         line_data <= '0;
         beat_cnt  <= '0;
         err       <= 1'b0;
         drop      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  araddr    <= req_addr & ~OFF_MASK;
                  beat_cnt  <= '0;
                  err       <= 1'b0;
                  drop      <= 1'b0;
                  line_err  <= 1'b0;
                  req_ready <= 1'b0;
                  arvalid   <= 1'b1;
                  state     <= ADDR;
               end
            end
            ADDR: begin
               // The request cannot be withdrawn once raised, so a flush only marks the line as dropped.
               if (flush) drop <= 1'b1;
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (flush) drop <= 1'b1;
               if (rvalid && rready) begin
                  line_data[int'(beat_cnt)*WORD_WIDTH +: WORD_WIDTH] <= rdata;
                  beat_cnt <= beat_cnt + CNT_W'(1);
                  err      <= err | beat_err;
                  // Stopping at the last slot keeps the counter from wrapping and refuses surplus beats.
                  if (last_slot || rlast) begin
                     rready    <= 1'b0;
                     line_pend <= !(drop || flush);
                     line_err  <= err | beat_err;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               line_pend <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               arvalid   <= 1'b0;
               rready    <= 1'b0;
               line_pend <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_refill.sv
// Directed testbench for icache_refill: a cycle-stepped AXI read slave model drives the R/AR
// channels while one initial block walks through refill, backpressure, error, flush and reset cases.
module tb_icache_refill;

   localparam int AW = 32;
   localparam int WW = 32;
   localparam int NB = 8;
   localparam int LW = NB * WW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic          flush = 1'b0;
   logic          line_valid;
   logic [LW-1:0] line_data;
   logic          line_err;
   logic          arvalid;
   logic          arready = 1'b0;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic [3:0]    arid;
   logic          rvalid = 1'b0;
   logic          rready;
   logic [WW-1:0] rdata = '0;
   logic [1:0]    rresp = 2'b00;
   logic          rlast = 1'b0;

   always #5 clk = ~clk;

   icache_refill #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BEATS(NB), .AXI_ID(0)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .flush(flush), .line_valid(line_valid), .line_data(line_data), .line_err(line_err),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arid(arid), .rvalid(rvalid), .rready(rready), .rdata(rdata),
      .rresp(rresp), .rlast(rlast)
   );

   int checks = 0;
   int passed = 0;

   // Slave configuration for the current directed step.
   int         ar_delay, n_beats, last_beat, err_beat, flush_beat, rst_beat;
   logic [7:0] gap_mask;
   logic [31:0] data_base;

   // Slave state and observations gathered over one request.
   int            ar_cnt, beat, cyc, lv_count, lv_cyc, busy, ar_cycles;
   bit            r_active, gap, accepted, snap_pending, ar_bad;
   logic [LW-1:0] lv_data;
   logic          lv_err, lv_rready;
   logic [AW-1:0] exp_araddr;
   logic [3:0]    snap;

   task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("[TB] check %s", tag);
      end
   endtask

   function automatic logic [LW-1:0] expLine(input logic [31:0] base);
      logic [LW-1:0] l;
      for (int k = 0; k < NB; k++) l[k*WW +: WW] = base + 32'(k);
      return l;
   endfunction

   task automatic setSlave(input int ard, input int nb, input int lb, input int eb, input int fb,
                           input logic [7:0] gm);
      ar_delay = ard; n_beats = nb; last_beat = lb; err_beat = eb; flush_beat = fb; gap_mask = gm;
      rst_beat = -1;
   endtask

   // One clock: capture handshakes before the edge, drive the slave after it, then sample outputs.
   task automatic tick();
      bit ar_hs, r_hs, req_hs, rst_seen;
      @(negedge clk);
      ar_hs    = arvalid && arready;
      r_hs     = rvalid && rready;
      req_hs   = req_valid && req_ready;
      rst_seen = rst;
      @(posedge clk);
      #1;
      cyc++;
      if (req_hs) begin
         req_valid = 1'b0;
         accepted  = 1'b1;
      end
      if (ar_hs) r_active = 1'b1;
      flush = 1'b0;
      gap   = 1'b0;
      if (r_hs) begin
         if (beat == flush_beat) flush = 1'b1;
         if (gap_mask[3'(beat)]) gap = 1'b1;
         beat++;
         if (beat >= n_beats) r_active = 1'b0;
      end
      if (rst_seen) begin
         r_active     = 1'b0;
         gap          = 1'b0;
         snap_pending = 1'b1;
      end
      rst = 1'b0;
      if (rst_beat >= 0 && r_active && beat == rst_beat) begin
         rst      = 1'b1;
         rst_beat = -1;
      end
      arready = arvalid && (ar_cnt == 0);
      if (arvalid && ar_cnt > 0) ar_cnt--;
      rvalid = r_active && !gap;
      rdata  = data_base + 32'(beat);
      rresp  = (r_active && beat == err_beat) ? 2'b10 : 2'b00;
      rlast  = r_active && (beat == last_beat);
      #1;
      if (line_valid) begin
         lv_count++;
         lv_cyc    = cyc;
         lv_data   = line_data;
         lv_err    = line_err;
         lv_rready = rready;
      end
      if (accepted && !req_ready) busy++;
      if (arvalid) begin
         ar_cycles++;
         if (araddr !== exp_araddr) ar_bad = 1'b1;
      end
      if (snap_pending) begin
         snap         = {arvalid, rready, req_ready, line_valid};
         snap_pending = 1'b0;
      end
   endtask

   // Issue one request and run the slave until the engine is idle again.
   task automatic applyStimulus(input logic [AW-1:0] addr, input logic [31:0] base,
                                input logic [AW-1:0] exp_addr);
      bit done;
      beat = 0; r_active = 0; gap = 0; accepted = 0; ar_bad = 0;
      lv_count = 0; lv_cyc = 0; busy = 0; ar_cycles = 0; cyc = 0;
      lv_data = '0; lv_err = 1'b0; lv_rready = 1'b0;
      ar_cnt = ar_delay; data_base = base; exp_araddr = exp_addr;
      req_addr = addr; req_valid = 1'b1;
      done = 0;
      for (int i = 0; i < 80 && !done; i++) begin
         tick();
         if (accepted && req_ready) done = 1;
      end
      if (!done) checkOutput("timeout", LW'(0), LW'(1));
   endtask

   initial begin
      setSlave(0, 8, 7, -1, -1, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checkOutput("rst_req_ready", LW'(req_ready), LW'(1));
      checkOutput("rst_arvalid", LW'(arvalid), LW'(0));
      checkOutput("rst_rready", LW'(rready), LW'(0));
      checkOutput("rst_line_valid", LW'(line_valid), LW'(0));
      checkOutput("rst_line_err", LW'(line_err), LW'(0));
      checkOutput("rst_line_data", line_data, LW'(0));

      $display("[TB] basic refill");
      setSlave(0, 8, 7, -1, -1, 8'h00);
      applyStimulus(32'h1C00_0014, 32'hA0, 32'h1C00_0000);
      checkOutput("basic_araddr", LW'(ar_bad), LW'(0));
      checkOutput("basic_ar_cycles", LW'(ar_cycles), LW'(1));
      checkOutput("basic_arlen", LW'(arlen), LW'(7));
      checkOutput("basic_arsize", LW'(arsize), LW'(2));
      checkOutput("basic_arburst", LW'(arburst), LW'(1));
      checkOutput("basic_arid", LW'(arid), LW'(0));
      checkOutput("basic_lv_count", LW'(lv_count), LW'(1));
      checkOutput("basic_latency", LW'(lv_cyc), LW'(10));
      checkOutput("basic_word0", LW'(lv_data[31:0]), LW'(32'hA0));
      checkOutput("basic_word7", LW'(lv_data[255:224]), LW'(32'hA7));
      checkOutput("basic_line", lv_data, expLine(32'hA0));
      checkOutput("basic_err", LW'(lv_err), LW'(0));
      checkOutput("basic_hold", line_data, expLine(32'hA0));

      $display("[TB] backpressure");
      setSlave(3, 8, 7, -1, -1, 8'b0010_0100);
      applyStimulus(32'h0000_1234, 32'hB0, 32'h0000_1220);
      checkOutput("bp_ar_stable", LW'(ar_bad), LW'(0));
      checkOutput("bp_ar_cycles", LW'(ar_cycles), LW'(4));
      checkOutput("bp_lv_count", LW'(lv_count), LW'(1));
      checkOutput("bp_latency", LW'(lv_cyc), LW'(15));
      checkOutput("bp_busy", LW'(busy), LW'(15));
      checkOutput("bp_line", lv_data, expLine(32'hB0));
      checkOutput("bp_err", LW'(lv_err), LW'(0));

      $display("[TB] bus error on beat 4");
      setSlave(0, 8, 7, 4, -1, 8'h00);
      applyStimulus(32'h0000_2000, 32'hC0, 32'h0000_2000);
      checkOutput("berr_beats", LW'(beat), LW'(8));
      checkOutput("berr_lv_count", LW'(lv_count), LW'(1));
      checkOutput("berr_err", LW'(lv_err), LW'(1));
      checkOutput("berr_line", lv_data, expLine(32'hC0));

      $display("[TB] early rlast on beat 5");
      setSlave(0, 6, 5, -1, -1, 8'h00);
      applyStimulus(32'h0000_3010, 32'hD0, 32'h0000_3000);
      checkOutput("early_beats", LW'(beat), LW'(6));
      checkOutput("early_lv_count", LW'(lv_count), LW'(1));
      checkOutput("early_latency", LW'(lv_cyc), LW'(8));
      checkOutput("early_err", LW'(lv_err), LW'(1));
      checkOutput("early_rready", LW'(lv_rready), LW'(0));
      checkOutput("early_word5", LW'(lv_data[191:160]), LW'(32'hD5));

      $display("[TB] flush after beat 3");
      setSlave(0, 8, 7, -1, 3, 8'h00);
      applyStimulus(32'h0000_4000, 32'hE0, 32'h0000_4000);
      checkOutput("flush_beats", LW'(beat), LW'(8));
      checkOutput("flush_lv_count", LW'(lv_count), LW'(0));
      checkOutput("flush_req_ready", LW'(req_ready), LW'(1));
      setSlave(0, 8, 7, -1, -1, 8'h00);
      applyStimulus(32'h0000_4020, 32'h60, 32'h0000_4020);
      checkOutput("postflush_lv_count", LW'(lv_count), LW'(1));
      checkOutput("postflush_line", lv_data, expLine(32'h60));
      checkOutput("postflush_err", LW'(lv_err), LW'(0));

      $display("[TB] reset during beat 6");
      setSlave(0, 8, 7, -1, -1, 8'h00);
      rst_beat = 6;
      applyStimulus(32'h2000_0040, 32'hF0, 32'h2000_0040);
      checkOutput("rstmid_outputs", LW'(snap), LW'(4'b0010));
      checkOutput("rstmid_lv_count", LW'(lv_count), LW'(0));
      setSlave(0, 8, 7, -1, -1, 8'h00);
      applyStimulus(32'h2000_007C, 32'h10, 32'h2000_0060);
      checkOutput("postrst_lv_count", LW'(lv_count), LW'(1));
      checkOutput("postrst_latency", LW'(lv_cyc), LW'(10));
      checkOutput("postrst_line", lv_data, expLine(32'h10));
      checkOutput("postrst_err", LW'(lv_err), LW'(0));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Memory-side refill engine for the instruction cache.
- On a miss it takes a line-aligned physical address from the cache controller and issues one AXI4 INCR read burst.
- It assembles the returned beats into one cache line and presents it as the block-wide refill data consumed by the ICache write path (I_WRITE).
- It sits between the ICache control FSM and the core's AXI read channel.

Parameters:
- ADDR_WIDTH, 32, physical address width.
- WORD_WIDTH, 32, AXI data beat width; one instruction word.
- BEATS, 8, words per cache line; must be a power of two ≥2.
- AXI_ID, 0, constant ARID driven on every request.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  refill request from ICache FSM.
- req_ready  out  1  engine idle and able to accept a request.
- req_addr  in  ADDR_WIDTH  miss physical address; offset bits ignored.
- flush  in  1  discard the in-flight refill (pipeline redirect).
- line_valid  out  1  one-cycle pulse: line_data valid.
- line_data  out  BEATS*WORD_WIDTH  refill block, word k at bits [k*WORD_WIDTH +: WORD_WIDTH].
- line_err  out  1  qualifies line_valid: bus error or protocol violation during burst.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- araddr  out  ADDR_WIDTH  burst start address.
- arlen  out  8  BEATS-1.
- arsize  out  3  log2(WORD_WIDTH/8).
- arburst  out  2  2'b01 (INCR).
- arid  out  4  AXI_ID.
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.
- rdata  in  WORD_WIDTH  beat data.
- rresp  in  2  beat response.
- rlast  in  1  last beat.

Behaviour:
- Reset values: req_ready=1, arvalid=0, rready=0, line_valid=0, line_err=0, line_data=0, beat counter=0, drop flag=0, state IDLE.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - req_ready=1.
  - When req_valid: latch araddr = {req_addr[ADDR_WIDTH-1:log2(BEATS*WORD_WIDTH/8)], zeros}, clear counter/err/drop, go to ADDR.
  - req_ready is 0 in every other state.
- ADDR:
  - arvalid=1; araddr/arlen/arsize/arburst/arid held stable until arready.
  - On arvalid&&arready: go to DATA. AR handshake takes ≥1 cycle.
- DATA:
  - rready=1.
  - Each rvalid&&rready writes rdata into word slot [counter], then counter++.
  - rresp != 2'b00 (beyond OKAY) sets err; err is sticky for the burst.
  - rlast on beat index < BEATS-1 sets err; the engine then ends the burst and goes to DONE.
  - Beat BEATS-1 without rlast sets err and goes to DONE; any extra beats are not accepted.
  - Beat BEATS-1 with rlast goes to DONE.
- DONE (one cycle):
  - line_valid=1 unless drop is set.
  - line_err = err.
  - Return to IDLE.
  - line_data stays stable until the next request is accepted.
- Latency: minimum 1 (AR) + BEATS (R) + 1 (DONE) cycles from acceptance to line_valid; 10 cycles for BEATS=8 with zero-wait slave.
- flush:
  - In IDLE: ignored.
  - In ADDR before the handshake: arvalid stays asserted until arready. AXI forbids withdrawing a request.
  - In ADDR or DATA: sets drop. The burst is drained fully, and DONE produces no line_valid.
  - In DONE: line_valid in that cycle is suppressed.
  - flush concurrent with req_valid in IDLE: the request is accepted normally.
- Reset mid-burst: returns to IDLE immediately with reset values. The system guarantees the interconnect is reset together.
- The counter width is log2(BEATS) and never wraps within a burst, because DONE is forced at beat BEATS-1.

Test Plan:
- Basic refill: req_addr=0x1C00_0014, zero-wait slave returning beats 0xA0..0xA7 with rlast on beat 7 -> araddr=0x1C00_0000, arlen=7, arsize=2, arburst=1; line_valid exactly 10 cycles after acceptance; line_data[31:0]=0xA0, [255:224]=0xA7; line_err=0.
- Backpressure: arready delayed 3 cycles, rvalid gaps after beats 2 and 5 -> AR fields stable while waiting; single line_valid pulse with correct data; req_ready=0 throughout.
- Bus error: rresp=2'b10 on beat 4 -> all 8 beats accepted; line_valid=1 with line_err=1.
- Early rlast on beat 5 -> DONE next cycle, line_err=1, rready deasserted afterward.
- Flush mid-DATA after beat 3 -> remaining beats drained, no line_valid, req_ready=1 after burst end; next request refills normally.
- Sync reset asserted during beat 6 -> next cycle arvalid=0, rready=0, req_ready=1, line_valid=0; a subsequent request completes correctly.
